// File: rtl/ysyx_24110015_pkg.sv
// ysyx_24110015_pkg
// Shared definitions for the LSU and its lane-alignment helper:
//   - MemOp encodings as driven by the IDU/EXU (in_mem_op)
//   - LSU handshake state enum
//   - fault-cause codes, kept here so a later CSR unit can derive mcause/mtval
//   - memop_illegal(): reserved MemOp encodings
package ysyx_24110015_pkg;

    localparam logic [2:0] MEMOP_B  = 3'b000;
    localparam logic [2:0] MEMOP_H  = 3'b001;
    localparam logic [2:0] MEMOP_W  = 3'b010;
    localparam logic [2:0] MEMOP_BU = 3'b100;
    localparam logic [2:0] MEMOP_HU = 3'b101;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_WAIT = 2'd2,
        LSU_DONE = 2'd3
    } lsu_state_t;

    // RISC-V exception codes the LSU can give rise to.
    localparam logic [3:0] CAUSE_ILLEGAL_INSN   = 4'd2;
    localparam logic [3:0] CAUSE_LOAD_MISALIGN  = 4'd4;
    localparam logic [3:0] CAUSE_LOAD_ACCESS    = 4'd5;
    localparam logic [3:0] CAUSE_STORE_MISALIGN = 4'd6;
    localparam logic [3:0] CAUSE_STORE_ACCESS   = 4'd7;

    // 011, 110 and 111 are not assigned to any access size.
    function automatic logic memop_illegal(input logic [2:0] op);
        return (op == 3'b011) || (op == 3'b110) || (op == 3'b111);
    endfunction

endpackage

// File: rtl/ysyx_24110015_lsu_align.sv
// ysyx_24110015_lsu_align
// Purely combinational byte-lane logic for the LSU.
// Ports:
//   op       in  3   MemOp code
//   addr_lo  in  2   address bits [1:0]
//   st_data  in  32  store data (rs2)
//   rd_word  in  32  word returned by the memory
//   wstrb    out 4   byte enables for a store of this size/offset
//   wdata    out 32  store data replicated onto every lane
//   ld_data  out 32  selected lane, sign- or zero-extended
//   misalign out 1   halfword on odd address or word not 4-aligned
module ysyx_24110015_lsu_align
    import ysyx_24110015_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] st_data,
    input  logic [31:0] rd_word,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] ld_data,
    output logic        misalign
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rd_word[7:0];
        case (addr_lo)
            2'd0:    byte_sel = rd_word[7:0];
            2'd1:    byte_sel = rd_word[15:8];
            2'd2:    byte_sel = rd_word[23:16];
            default: byte_sel = rd_word[31:24];
        endcase
        half_sel = addr_lo[1] ? rd_word[31:16] : rd_word[15:0];
    end

    // op[1:0] carries the size; op[2] only selects zero extension.
    always_comb begin
        wstrb = 4'b1111;
        wdata = st_data;
        case (op[1:0])
            2'b00: begin
                wstrb = 4'b0001 << addr_lo;
                wdata = {4{st_data[7:0]}};
            end
            2'b01: begin
                wstrb = 4'b0011 << {addr_lo[1], 1'b0};
                wdata = {2{st_data[15:0]}};
            end
            default: begin
                wstrb = 4'b1111;
                wdata = st_data;
            end
        endcase
    end

    always_comb begin
        ld_data = rd_word;
        case (op)
            MEMOP_B:  ld_data = {{24{byte_sel[7]}}, byte_sel};
            MEMOP_BU: ld_data = {24'b0, byte_sel};
            MEMOP_H:  ld_data = {{16{half_sel[15]}}, half_sel};
            MEMOP_HU: ld_data = {16'b0, half_sel};
            default:  ld_data = rd_word;
        endcase
    end

    assign misalign = ((op[1:0] == 2'b01) && addr_lo[0]) ||
                      ((op[1:0] == 2'b10) && (addr_lo != 2'b00));

endmodule

// File: rtl/ysyx_24110015_lsu.sv
// ysyx_24110015_lsu
// Multi-cycle load/store unit behind the EXU. One operation in flight:
// accept -> (optional single word-aligned bus request -> response) -> result.
// Non-memory ops pass in_addr through with one cycle of latency.
// Ports:
//   clk, rst                       clock, async active-high reset
//   in_valid/in_ready              EXU -> LSU operation handshake
//   in_addr, in_wdata              effective address / pass-through, store data
//   in_mem_read/write, in_mem_op   access kind and MemOp code
//   req_valid/req_ready            data-memory request handshake
//   req_addr/wen/wdata/wstrb       word-aligned request, replicated lanes
//   rsp_valid, rsp_data, rsp_err   single-cycle response / write ack
//   out_valid/out_ready            LSU -> writeback handshake
//   out_data, out_fault            result word and fault flag
module ysyx_24110015_lsu
    import ysyx_24110015_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic        in_mem_read,
    input  logic        in_mem_write,
    input  logic [2:0]  in_mem_op,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [31:0] req_addr,
    output logic        req_wen,
    output logic [31:0] req_wdata,
    output logic [3:0]  req_wstrb,
    input  logic        rsp_valid,
    input  logic [31:0] rsp_data,
    input  logic        rsp_err,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_fault
);

    lsu_state_t  state_q, state_d;
    logic [31:0] addr_q, wdata_q;
    logic        read_q, write_q;
    logic [2:0]  op_q;
    logic [31:0] out_data_q, out_data_d;
    logic        out_fault_q, out_fault_d;
    logic        accept;
    logic        reject;

    logic        idle;
    logic [2:0]  al_op;
    logic [1:0]  al_addr;
    logic [3:0]  al_wstrb;
    logic [31:0] al_wdata;
    logic [31:0] al_ld_data;
    logic        al_misalign;

    assign idle     = (state_q == LSU_IDLE);
    assign in_ready = idle & ~rst;
    assign accept   = in_valid & in_ready;

    // In IDLE the aligner looks at the incoming op so misalignment can be
    // decided at accept time; afterwards it works on the registered op.
    assign al_op   = idle ? in_mem_op     : op_q;
    assign al_addr = idle ? in_addr[1:0]  : addr_q[1:0];

    ysyx_24110015_lsu_align u_align (
        .op       (al_op),
        .addr_lo  (al_addr),
        .st_data  (wdata_q),
        .rd_word  (rsp_data),
        .wstrb    (al_wstrb),
        .wdata    (al_wdata),
        .ld_data  (al_ld_data),
        .misalign (al_misalign)
    );

    // Anything that must not reach the bus: ambiguous access kind, reserved
    // encoding, unsigned store, or a misaligned address.
    assign reject = (in_mem_read & in_mem_write) |
                    memop_illegal(in_mem_op) |
                    (in_mem_write & in_mem_op[2]) |
                    al_misalign;

    always_comb begin
        state_d     = state_q;
        out_data_d  = out_data_q;
        out_fault_d = out_fault_q;
        unique case (state_q)
            LSU_IDLE: begin
                if (accept) begin
                    if (!in_mem_read && !in_mem_write) begin
                        state_d     = LSU_DONE;
                        out_data_d  = in_addr;
                        out_fault_d = 1'b0;
                    end else if (reject) begin
                        state_d     = LSU_DONE;
                        out_data_d  = 32'b0;
                        out_fault_d = 1'b1;
                    end else begin
                        state_d = LSU_REQ;
                    end
                end
            end
            LSU_REQ: begin
                if (req_ready) state_d = LSU_WAIT;
            end
            LSU_WAIT: begin
                if (rsp_valid) begin
                    state_d = LSU_DONE;
                    if (rsp_err) begin
                        out_data_d  = 32'b0;
                        out_fault_d = 1'b1;
                    end else if (write_q) begin
                        out_data_d  = 32'b0;
                        out_fault_d = 1'b0;
                    end else begin
                        out_data_d  = al_ld_data;
                        out_fault_d = 1'b0;
                    end
                end
            end
            LSU_DONE: begin
                if (out_ready) state_d = LSU_IDLE;
            end
            default: state_d = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= LSU_IDLE;
            addr_q      <= 32'b0;
            wdata_q     <= 32'b0;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            op_q        <= 3'b0;
            out_data_q  <= 32'b0;
            out_fault_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            out_fault_q <= out_fault_d;
            if (accept) begin
                addr_q  <= in_addr;
                wdata_q <= in_wdata;
                read_q  <= in_mem_read;
                write_q <= in_mem_write;
                op_q    <= in_mem_op;
            end
        end
    end

    // Write-side request fields are forced to zero outside a pending store so
    // the bus sees clean values on reads and while idle.
    logic req_store;
    assign req_store = (state_q == LSU_REQ) & write_q & ~read_q;

    assign req_valid = (state_q == LSU_REQ);
    assign req_addr  = {addr_q[31:2], 2'b00};
    assign req_wen   = req_store;
    assign req_wstrb = req_store ? al_wstrb : 4'b0000;
    assign req_wdata = req_store ? al_wdata : 32'b0;

    assign out_valid = (state_q == LSU_DONE);
    assign out_data  = out_data_q;
    assign out_fault = out_fault_q;

endmodule

// File: tb/tb_ysyx_24110015_lsu.sv
module tb_ysyx_24110015_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_addr = '0;
    logic [31:0] in_wdata = '0;
    logic        in_mem_read = 1'b0;
    logic        in_mem_write = 1'b0;
    logic [2:0]  in_mem_op = '0;
    logic        req_valid;
    logic        req_ready = 1'b0;
    logic [31:0] req_addr;
    logic        req_wen;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_data = '0;
    logic        rsp_err = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_fault;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ysyx_24110015_lsu dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_wdata(in_wdata),
        .in_mem_read(in_mem_read), .in_mem_write(in_mem_write), .in_mem_op(in_mem_op),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wen(req_wen), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_fault(out_fault)
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic        bus;
        logic        wen;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic [31:0] data;
        logic        fault;
    } exp_t;

    function automatic exp_t model(input logic rd, input logic wr, input logic [2:0] op,
                                   input logic [31:0] addr, input logic [31:0] wd,
                                   input logic [31:0] rdw, input logic err);
        exp_t e;
        int unsigned size, off, v;
        logic uns, bad;
        e.bus = 0; e.wen = 0; e.strb = 0; e.wdata = 0; e.data = 0; e.fault = 0;
        if (!rd && !wr) begin
            e.data = addr;
            return e;
        end
        size = op % 4;
        uns  = (op >= 4);
        off  = addr % 4;
        bad  = (op == 3) || (op == 6) || (op == 7) || (rd && wr) || (wr && uns) ||
               (size == 1 && (addr % 2) != 0) || (size == 2 && off != 0);
        if (bad) begin
            e.fault = 1;
            return e;
        end
        e.bus = 1;
        if (wr) begin
            e.wen = 1;
            if (size == 0) begin
                e.strb = 4'(1 << off);
                e.wdata = (wd & 32'hFF) * 32'h01010101;
            end else if (size == 1) begin
                e.strb = 4'(3 << off);
                e.wdata = (wd & 32'hFFFF) * 32'h00010001;
            end else begin
                e.strb = 4'hF;
                e.wdata = wd;
            end
        end
        if (err) begin
            e.fault = 1;
        end else if (rd) begin
            if (size == 0) begin
                v = (rdw >> (8 * off)) & 32'hFF;
                if (!uns && v >= 128) v = v - 256;
            end else if (size == 1) begin
                v = (rdw >> (8 * off)) & 32'hFFFF;
                if (!uns && v >= 32768) v = v - 65536;
            end else begin
                v = rdw;
            end
            e.data = v;
        end
        return e;
    endfunction

    // ---------------- driver / observer ----------------
    logic        r_saw_req, r_req_stable, r_out_stable, r_inready_bad, r_timeout;
    logic        r_pre_ready, r_post_ready, r_wen, r_fault;
    logic [31:0] r_req_addr, r_wdata, r_data;
    logic [3:0]  r_strb;
    int          r_req_hs, r_out_lat;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic rd, input logic wr, input logic [2:0] op,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] rdw, input logic err,
                         input int rqd, input int rsd, input int otd, input logic stale);
        int cyc, rq_wait, rs_wait, ot_wait;
        logic hs_done, hs_now, rsp_sent, fin;
        r_saw_req = 0; r_req_stable = 1; r_out_stable = 1; r_inready_bad = 0;
        r_req_hs = 0; r_out_lat = -1; r_req_addr = 0; r_wen = 0; r_strb = 0;
        r_wdata = 0; r_data = 0; r_fault = 0;
        r_pre_ready = in_ready;
        in_valid = 1; in_mem_read = rd; in_mem_write = wr; in_mem_op = op;
        in_addr = addr; in_wdata = wd;
        tick();
        in_valid = 0; in_mem_read = 0; in_mem_write = 0;
        in_addr = $urandom; in_wdata = $urandom; in_mem_op = 3'($urandom);
        cyc = 1; rq_wait = 0; rs_wait = 0; ot_wait = 0;
        hs_done = 0; rsp_sent = 0; fin = 0;
        while (!fin && cyc < 40) begin
            rsp_valid = 0; rsp_err = 0; req_ready = 0; out_ready = 0; hs_now = 0;
            rsp_data = $urandom;
            if (in_ready) r_inready_bad = 1;
            if (hs_done && !rsp_sent) begin
                if (rs_wait == rsd) begin
                    rsp_valid = 1; rsp_data = rdw; rsp_err = err; rsp_sent = 1;
                end
                rs_wait++;
            end
            if (req_valid) begin
                if (!r_saw_req) begin
                    r_saw_req = 1; r_req_addr = req_addr; r_wen = req_wen;
                    r_strb = req_wstrb; r_wdata = req_wdata;
                end else if (req_addr !== r_req_addr || req_wen !== r_wen ||
                             req_wstrb !== r_strb || req_wdata !== r_wdata) begin
                    r_req_stable = 0;
                end
                if (rq_wait >= rqd) begin
                    req_ready = 1; r_req_hs++; hs_now = 1;
                    // a response in the handshake cycle must be ignored
                    if (stale) begin
                        rsp_valid = 1; rsp_data = ~rdw; rsp_err = 1;
                    end
                end
                rq_wait++;
            end
            if (hs_now) hs_done = 1;
            if (out_valid) begin
                if (r_out_lat < 0) begin
                    r_out_lat = cyc; r_data = out_data; r_fault = out_fault;
                end else if (out_data !== r_data || out_fault !== r_fault) begin
                    r_out_stable = 0;
                end
                if (ot_wait >= otd) begin
                    out_ready = 1; fin = 1;
                end
                ot_wait++;
            end
            tick();
            cyc++;
        end
        rsp_valid = 0; rsp_err = 0; req_ready = 0; out_ready = 0;
        r_timeout = !fin;
        r_post_ready = in_ready;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1;
        tick(); tick();
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        n_tests++; if (req_valid !== 1'b0 || req_wen !== 1'b0) begin n_fail++; $display("FAIL reset_req got valid=%b wen=%b exp=0", req_valid, req_wen); end
        n_tests++; if (req_wstrb !== 4'h0 || req_addr !== 32'h0 || req_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_req_fields got strb=%h addr=%h wdata=%h exp=0", req_wstrb, req_addr, req_wdata); end
        n_tests++; if (out_valid !== 1'b0 || out_data !== 32'h0 || out_fault !== 1'b0) begin n_fail++; $display("FAIL reset_out got v=%b d=%h f=%b exp=0", out_valid, out_data, out_fault); end
        rst = 0;
        tick();
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_store_word();
        do_op(0, 1, 3'b010, 32'h80000104, 32'hDEADBEEF, 32'h0, 0, 0, 0, 0, 0);
        n_tests++; if (r_saw_req !== 1'b1 || r_req_addr !== 32'h80000104) begin n_fail++; $display("FAIL sw_req_addr got saw=%b addr=%h exp=80000104", r_saw_req, r_req_addr); end
        n_tests++; if (r_wen !== 1'b1 || r_strb !== 4'hF || r_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sw_req_fields got wen=%b strb=%h wdata=%h exp=1/f/deadbeef", r_wen, r_strb, r_wdata); end
        n_tests++; if (r_data !== 32'h0 || r_fault !== 1'b0) begin n_fail++; $display("FAIL sw_out got d=%h f=%b exp=0/0", r_data, r_fault); end
        n_tests++; if (r_out_lat !== 3 || r_timeout) begin n_fail++; $display("FAIL sw_latency got=%0d timeout=%b exp=3", r_out_lat, r_timeout); end
    endtask

    task automatic test_loads();
        logic [2:0]  ops [4]  = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] adr [4]  = '{32'h80000003, 32'h80000003, 32'h80000002, 32'h80000002};
        logic [31:0] rw  [4]  = '{32'h80FF1234, 32'h80FF1234, 32'h80010000, 32'h80010000};
        logic [31:0] exd [4]  = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h00008001};
        for (int i = 0; i < 4; i++) begin
            do_op(1, 0, ops[i], adr[i], 32'h0, rw[i], 0, 0, 0, 0, 0);
            n_tests++; if (r_data !== exd[i] || r_fault !== 1'b0) begin n_fail++; $display("FAIL load%0d_data got d=%h f=%b exp=%h/0", i, r_data, r_fault, exd[i]); end
            n_tests++; if (r_req_addr !== 32'h80000000 || r_wen !== 1'b0 || r_strb !== 4'h0) begin n_fail++; $display("FAIL load%0d_req got addr=%h wen=%b strb=%h exp=80000000/0/0", i, r_req_addr, r_wen, r_strb); end
        end
    endtask

    task automatic test_store_half();
        do_op(0, 1, 3'b001, 32'h80000002, 32'h1234ABCD, 32'h0, 0, 0, 0, 0, 0);
        n_tests++; if (r_strb !== 4'b1100 || r_wdata !== 32'hABCDABCD || r_req_addr !== 32'h80000000) begin n_fail++; $display("FAIL sh_req got strb=%b wdata=%h addr=%h exp=1100/abcdabcd/80000000", r_strb, r_wdata, r_req_addr); end
        do_op(0, 1, 3'b000, 32'h80000001, 32'h000000A5, 32'h0, 0, 0, 0, 0, 0);
        n_tests++; if (r_strb !== 4'b0010 || r_wdata !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL sb_req got strb=%b wdata=%h exp=0010/a5a5a5a5", r_strb, r_wdata); end
    endtask

    task automatic test_fault();
        do_op(1, 0, 3'b010, 32'h80000006, 32'h0, 32'h0, 0, 0, 0, 0, 0);
        n_tests++; if (r_saw_req !== 1'b0) begin n_fail++; $display("FAIL lw_misalign_noreq got req=%b exp=0", r_saw_req); end
        n_tests++; if (r_out_lat !== 1 || r_fault !== 1'b1 || r_data !== 32'h0) begin n_fail++; $display("FAIL lw_misalign_out got lat=%0d f=%b d=%h exp=1/1/0", r_out_lat, r_fault, r_data); end
        do_op(1, 0, 3'b011, 32'h80000008, 32'h0, 32'h0, 0, 0, 0, 0, 0);
        n_tests++; if (r_saw_req !== 1'b0 || r_out_lat !== 1 || r_fault !== 1'b1 || r_data !== 32'h0) begin n_fail++; $display("FAIL illegal_op got req=%b lat=%0d f=%b d=%h exp=0/1/1/0", r_saw_req, r_out_lat, r_fault, r_data); end
        do_op(1, 0, 3'b010, 32'h80000010, 32'h0, 32'h12345678, 1, 0, 0, 0, 0);
        n_tests++; if (r_saw_req !== 1'b1 || r_fault !== 1'b1 || r_data !== 32'h0) begin n_fail++; $display("FAIL bus_err got req=%b f=%b d=%h exp=1/1/0", r_saw_req, r_fault, r_data); end
    endtask

    task automatic test_backpressure();
        do_op(1, 0, 3'b010, 32'h80000020, 32'h0, 32'hCAFEF00D, 0, 3, 2, 2, 1);
        n_tests++; if (r_req_stable !== 1'b1 || r_out_stable !== 1'b1) begin n_fail++; $display("FAIL bp_stable got req=%b out=%b exp=1/1", r_req_stable, r_out_stable); end
        n_tests++; if (r_inready_bad !== 1'b0 || r_req_hs !== 1) begin n_fail++; $display("FAIL bp_handshakes got in_ready_seen=%b req_hs=%0d exp=0/1", r_inready_bad, r_req_hs); end
        n_tests++; if (r_out_lat !== 8 || r_data !== 32'hCAFEF00D || r_fault !== 1'b0) begin n_fail++; $display("FAIL bp_out got lat=%0d d=%h f=%b exp=8/cafef00d/0", r_out_lat, r_data, r_fault); end
        n_tests++; if (r_post_ready !== 1'b1 || r_timeout) begin n_fail++; $display("FAIL bp_return_idle got in_ready=%b timeout=%b exp=1/0", r_post_ready, r_timeout); end
    endtask

    task automatic test_reset_in_wait();
        logic seen;
        in_valid = 1; in_mem_read = 1; in_mem_write = 0; in_mem_op = 3'b010; in_addr = 32'h80000040;
        tick();
        in_valid = 0; in_mem_read = 0; req_ready = 1;
        tick();
        req_ready = 0;
        rst = 1;
        #1;
        n_tests++; if (in_ready !== 1'b0 || req_valid !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_wait_during got in_ready=%b req=%b out=%b exp=0/0/0", in_ready, req_valid, out_valid); end
        tick(); tick();
        rst = 0;
        rsp_valid = 1; rsp_data = 32'h55AA55AA; rsp_err = 0;
        tick();
        rsp_valid = 0;
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            if (out_valid || req_valid) seen = 1;
            tick();
        end
        n_tests++; if (seen !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_wait_stale got activity=%b in_ready=%b exp=0/1", seen, in_ready); end
        do_op(1, 0, 3'b101, 32'h80000042, 32'h0, 32'hBEEF1234, 0, 0, 0, 0, 0);
        n_tests++; if (r_data !== 32'h0000BEEF || r_fault !== 1'b0 || r_out_lat !== 3) begin n_fail++; $display("FAIL rst_wait_next got d=%h f=%b lat=%0d exp=0000beef/0/3", r_data, r_fault, r_out_lat); end
    endtask

    task automatic test_passthrough();
        do_op(0, 0, 3'b010, 32'h12345678, 32'h0, 32'h0, 0, 0, 0, 0, 0);
        n_tests++; if (r_out_lat !== 1 || r_data !== 32'h12345678 || r_fault !== 1'b0 || r_saw_req !== 1'b0) begin n_fail++; $display("FAIL passthrough got lat=%0d d=%h f=%b req=%b exp=1/12345678/0/0", r_out_lat, r_data, r_fault, r_saw_req); end
    endtask

    task automatic test_random();
        logic [2:0] legal [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        for (int it = 0; it < 80; it++) begin
            logic rd, wr, err, stale;
            logic [2:0] op;
            logic [31:0] addr, wd, rdw;
            int kind, rqd, rsd, otd, elat;
            exp_t e;
            kind = $urandom_range(0, 9);
            rd = (kind >= 2 && kind <= 5) || kind == 9;
            wr = (kind >= 6);
            op = ($urandom_range(0, 3) != 0) ? legal[$urandom_range(0, 4)] : 3'($urandom);
            addr = $urandom; wd = $urandom; rdw = $urandom;
            err = ($urandom_range(0, 7) == 0);
            stale = $urandom_range(0, 1);
            rqd = $urandom_range(0, 2); rsd = $urandom_range(0, 2); otd = $urandom_range(0, 2);
            e = model(rd, wr, op, addr, wd, rdw, err);
            elat = e.bus ? 3 + rqd + rsd : 1;
            do_op(rd, wr, op, addr, wd, rdw, err, rqd, rsd, otd, stale);
            n_tests++; if (r_pre_ready !== 1'b1 || r_timeout) begin n_fail++; $display("FAIL rnd%0d_flow got in_ready=%b timeout=%b exp=1/0", it, r_pre_ready, r_timeout); end
            n_tests++; if (r_saw_req !== e.bus || r_out_lat !== elat) begin n_fail++; $display("FAIL rnd%0d_path got req=%b lat=%0d exp=%b/%0d (rd=%b wr=%b op=%b addr=%h)", it, r_saw_req, r_out_lat, e.bus, elat, rd, wr, op, addr); end
            n_tests++; if (r_data !== e.data || r_fault !== e.fault) begin n_fail++; $display("FAIL rnd%0d_out got d=%h f=%b exp=%h/%b (rd=%b wr=%b op=%b addr=%h)", it, r_data, r_fault, e.data, e.fault, rd, wr, op, addr); end
            if (e.bus) begin
                n_tests++; if (r_req_addr !== {addr[31:2], 2'b00} || r_wen !== e.wen || r_strb !== e.strb) begin n_fail++; $display("FAIL rnd%0d_req got addr=%h wen=%b strb=%b exp=%h/%b/%b", it, r_req_addr, r_wen, r_strb, {addr[31:2], 2'b00}, e.wen, e.strb); end
                if (wr) begin
                    n_tests++; if (r_wdata !== e.wdata) begin n_fail++; $display("FAIL rnd%0d_wdata got=%h exp=%h", it, r_wdata, e.wdata); end
                end
                n_tests++; if (r_req_stable !== 1'b1 || r_out_stable !== 1'b1 || r_req_hs !== 1) begin n_fail++; $display("FAIL rnd%0d_stable got req=%b out=%b hs=%0d exp=1/1/1", it, r_req_stable, r_out_stable, r_req_hs); end
            end
            n_tests++; if (r_inready_bad !== 1'b0 || r_post_ready !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_in_ready got busy_ready=%b after=%b exp=0/1", it, r_inready_bad, r_post_ready); end
        end
    endtask

    initial begin
        test_reset();
        test_store_word();
        test_loads();
        test_store_half();
        test_fault();
        test_backpressure();
        test_reset_in_wait();
        test_passthrough();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
